// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side microbranch predictor with 2-bit counter table,
// in-order pending queue, checker-driven training and registered flush pulse.
//   Parameters: AW (table index width, 2^AW entries), DEPTH (queue depth, pow2).
//   Fetch side : fetch_br, fetch_pc, fetch_type -> pred_taken, pred_type, stall.
//   Check side : chk_checked, chk_incorrect, chk_correct -> flush (1-cycle).
//   Optional   : BP_STATS_EN adds check_cnt / mispred_cnt (16-bit, saturating).
module branch_predictor #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_br,
  input  logic [AW-1:0] fetch_pc,
  input  logic [1:0]    fetch_type,
  output logic          pred_taken,
  output logic [1:0]    pred_type,
  output logic          stall,
  input  logic          chk_checked,
  input  logic          chk_incorrect,
  input  logic          chk_correct,
  output logic          flush
`ifdef BP_STATS_EN
  ,
  output logic [15:0]   mispred_cnt,
  output logic [15:0]   check_cnt
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int ENT = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          pred;
  } entry_t;

  logic [1:0]    tbl_q [ENT];
  logic [1:0]    tbl_d [ENT];
  entry_t        q_q   [DEPTH];
  entry_t        q_d   [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          flush_cond;
  entry_t        head_ent;
  logic [1:0]    cur_ctr;
  logic [1:0]    new_ctr;
  logic          unused_pred;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign stall      = fetch_br && full;
  assign pop        = chk_checked && !empty;
  assign flush_cond = pop && chk_incorrect;
  assign push       = fetch_br && !full && !flush_cond;

  assign pred_taken = fetch_br && tbl_q[fetch_pc][1];
  assign pred_type  = fetch_type;
  assign flush      = flush_q;

  assign head_ent    = q_q[head_q];
  assign cur_ctr     = tbl_q[head_ent.pc];
  // The stored guess travels with the entry but training uses only the outcome.
  assign unused_pred = head_ent.pred;

  always_comb begin
    new_ctr = cur_ctr;
    unique case (1'b1)
      chk_correct:  new_ctr = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
      !chk_correct: new_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
      default:      new_ctr = cur_ctr;
    endcase
  end

  always_comb begin
    tbl_d = tbl_q;
    if (pop) begin
      tbl_d[head_ent.pc] = new_ctr;
    end
  end

  always_comb begin
    q_d = q_q;
    if (push) begin
      q_d[tail_q] = '{pc: fetch_pc, pred: pred_taken};
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    flush_d = flush_cond;
    if (flush_cond) begin
      // Drop everything younger than the head: both pointers land past it.
      head_d = head_q + PW'(1);
      tail_d = head_q + PW'(1);
      cnt_d  = '0;
    end else begin
      head_d = head_q + PW'(pop);
      tail_d = tail_q + PW'(push);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT; i++) begin
        tbl_q[i] <= 2'b01;
      end
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      tbl_q   <= tbl_d;
      q_q     <= q_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] chk_cnt_q, chk_cnt_d;
  logic [15:0] mis_cnt_q, mis_cnt_d;

  assign check_cnt   = chk_cnt_q;
  assign mispred_cnt = mis_cnt_q;

  always_comb begin
    chk_cnt_d = chk_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (pop && (chk_cnt_q != 16'hFFFF)) begin
      chk_cnt_d = chk_cnt_q + 16'd1;
    end
    if (flush_cond && (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_d = mis_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      chk_cnt_q <= chk_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
`endif

endmodule
